// File: rtl/pipe_dmem_arb.sv
`default_nettype none
// ============================================================================
// Module   : pipe_dmem_arb
// Purpose  : Arbitrates one single-port memory between the MEM stage
//            (load/store) and the IF stage (fetch). It runs each access through
//            a request/ready handshake, returns registered read data and a
//            one-cycle ack, and stalls the pipeline while any request is
//            still waiting for its ack. MEM normally has priority. IF wins
//            once it has lost MAX_STARVE arbitrations in a row.
// Options  : PIPE_ARB_TIMEOUT_EN - bounds each ACCESS to TIMEOUT_CYCLES.
//            On expiry it returns 32'hDEADBEEF and sets the sticky err flag.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_dmem_arb #(
  parameter int MAX_STARVE     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic [31:0] m_rdata,
  output logic        m_ack,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] MAX_S = 4'(MAX_STARVE);

  state_t      state_q;
  logic        win_if_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  starve_q;
  logic [31:0] m_rdata_q;
  logic [31:0] i_rdata_q;
  logic        m_ack_q;
  logic        i_ack_q;
  logic        mem_req_q;
  logic        grant_if;

  // IF takes the grant when it is alone, or when it has starved long enough.
  assign grant_if = i_req & (~m_req | (starve_q == MAX_S));

`ifdef PIPE_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q;
  logic          err_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  // Arbitration FSM: grant in IDLE, hold the access in ACCESS, pulse ack in RESP.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= S_IDLE;
      win_if_q  <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      starve_q  <= '0;
      m_rdata_q <= '0;
      i_rdata_q <= '0;
      m_ack_q   <= 1'b0;
      i_ack_q   <= 1'b0;
      mem_req_q <= 1'b0;
`ifdef PIPE_ARB_TIMEOUT_EN
      tcnt_q    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      m_ack_q <= 1'b0;
      i_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (m_req | i_req) begin
            if (grant_if) begin
              win_if_q <= 1'b1;
              we_q     <= 1'b0;
              addr_q   <= i_addr;
              wdata_q  <= '0;
              starve_q <= '0;
            end else begin
              win_if_q <= 1'b0;
              we_q     <= m_we;
              addr_q   <= m_addr;
              wdata_q  <= m_wdata;
              if (i_req && (starve_q != MAX_S)) starve_q <= starve_q + 4'd1;
            end
            mem_req_q <= 1'b1;
            state_q   <= S_ACCESS;
`ifdef PIPE_ARB_TIMEOUT_EN
            tcnt_q    <= '0;
`endif
          end
        end
        S_ACCESS: begin
          if (mem_ready) begin
            mem_req_q <= 1'b0;
            state_q   <= S_RESP;
            if (win_if_q) begin
              i_ack_q <= 1'b1;
              if (!we_q) i_rdata_q <= mem_rdata;
            end else begin
              m_ack_q <= 1'b1;
              if (!we_q) m_rdata_q <= mem_rdata;
            end
          end
`ifdef PIPE_ARB_TIMEOUT_EN
          else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            mem_req_q <= 1'b0;
            state_q   <= S_RESP;
            err_q     <= 1'b1;
            if (win_if_q) begin
              i_ack_q   <= 1'b1;
              i_rdata_q <= 32'hDEADBEEF;
            end else begin
              m_ack_q   <= 1'b1;
              m_rdata_q <= 32'hDEADBEEF;
            end
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
`endif
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign m_rdata   = m_rdata_q;
  assign i_rdata   = i_rdata_q;
  assign m_ack     = m_ack_q;
  assign i_ack     = i_ack_q;
  assign stall     = (m_req & ~m_ack_q) | (i_req & ~i_ack_q);
`ifdef PIPE_ARB_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_dmem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_dmem_arb
// Purpose  : Randomized self-checking bench for pipe_dmem_arb. It uses a
//            transaction-level timeline model: grant cycle, wait states,
//            ack cycle, starvation count and a sparse memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_dmem_arb;

  localparam int MAX_ST = 2;
  localparam int TMO    = 8;
  localparam int NCYC   = 3000;

  logic        clk = 1'b0;
  logic        clrn;
  logic        m_req, m_we, i_req, mem_ready;
  logic [31:0] m_addr, m_wdata, i_addr, mem_rdata;
  logic [31:0] m_rdata, i_rdata, mem_addr, mem_wdata;
  logic        m_ack, i_ack, mem_req, mem_we, stall, err;

  pipe_dmem_arb #(.MAX_STARVE(MAX_ST), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .clrn(clrn),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Sparse memory behind the arbiter
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  // Reference model state
  bit          busy, win_if, tmo, lat_we, ack_m_prev, ack_i_prev, e_err;
  int          g, w, free_from, starve, resets;
  logic [31:0] lat_addr, lat_wdata, rd_val, e_m_rd, e_i_rd;
  // Requester agents
  bit          m_pend, i_pend;

  task automatic model_reset();
    busy = 0; free_from = 0; starve = 0; e_m_rd = '0; e_i_rd = '0; e_err = 0;
    m_pend = 0; i_pend = 0; ack_m_prev = 0; ack_i_prev = 0;
    m_req = 0; i_req = 0; m_we = 0; mem_ready = 0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_mem_req"}, mem_req, 0);
    chk({pfx, "_mem_we"},  mem_we, 0);
    chk({pfx, "_mem_addr"}, mem_addr, 0);
    chk({pfx, "_m_ack"}, m_ack, 0);
    chk({pfx, "_i_ack"}, i_ack, 0);
    chk({pfx, "_m_rdata"}, m_rdata, 0);
    chk({pfx, "_i_rdata"}, i_rdata, 0);
    chk({pfx, "_stall"}, stall, 0);
    chk({pfx, "_err"}, err, 0);
  endtask

  initial begin
    bit e_mreq, e_am, e_ai, both;
    clrn = 1'b0; m_addr = '0; m_wdata = '0; i_addr = '0; mem_rdata = '0;
    resets = 0;
    model_reset();
    #12;
    chk_reset_outputs("rst");
    @(negedge clk) clrn = 1'b1;

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk); #1;

      // Requesters: after an ack cycle the request may change
      if (ack_m_prev) m_pend = 0;
      if (ack_i_prev) i_pend = 0;
      if (!m_pend && ($urandom_range(0, 99) < ((c < NCYC / 2) ? 85 : 40))) begin
        m_pend  = 1;
        m_we    = $urandom_range(0, 1);
        m_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        m_wdata = $urandom;
      end
      if (!i_pend && ($urandom_range(0, 99) < 70)) begin
        i_pend = 1;
        i_addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      end
      m_req = m_pend;
      i_req = i_pend;

      // Arbitration decision at an idle cycle
      if (!busy && c >= free_from && (m_req || i_req)) begin
        both   = m_req && i_req;
        win_if = i_req && (!m_req || starve == MAX_ST);
        if (win_if) starve = 0;
        else if (i_req) starve = (starve + 1 > MAX_ST) ? MAX_ST : starve + 1;
        lat_we    = win_if ? 1'b0 : m_we;
        lat_addr  = win_if ? i_addr : m_addr;
        lat_wdata = m_wdata;
`ifdef PIPE_ARB_TIMEOUT_EN
        tmo = ($urandom_range(0, 19) == 0);
`else
        tmo = 0;
`endif
        w    = tmo ? TMO - 1 : $urandom_range(0, 3);
        g    = c;
        busy = 1;
      end

      e_mreq = busy && (c >= g + 1) && (c <= g + 1 + w);
      e_am   = busy && (c == g + 2 + w) && !win_if;
      e_ai   = busy && (c == g + 2 + w) && win_if;

      // Memory side
      mem_ready = 0;
      mem_rdata = $urandom;
      if (busy && c == g + 1 + w && !tmo) begin
        mem_ready = 1;
        if (lat_we) mem[lat_addr] = lat_wdata;
        else begin
          rd_val    = memval(lat_addr);
          mem_rdata = rd_val;
        end
      end
      if (busy && c == g + 2 + w) begin
        if (tmo) begin
          e_err = 1;
          if (win_if) e_i_rd = 32'hDEADBEEF; else e_m_rd = 32'hDEADBEEF;
        end else if (!lat_we) begin
          if (win_if) e_i_rd = rd_val; else e_m_rd = rd_val;
        end
      end

      #1;
      chk("mem_req", mem_req, e_mreq);
      if (e_mreq) begin
        chk("mem_we", mem_we, lat_we);
        chk("mem_addr", mem_addr, lat_addr);
        if (lat_we) chk("mem_wdata", mem_wdata, lat_wdata);
      end
      chk("m_ack", m_ack, e_am);
      chk("i_ack", i_ack, e_ai);
      chk("m_rdata", m_rdata, e_m_rd);
      chk("i_rdata", i_rdata, e_i_rd);
      chk("stall", stall, (m_req & ~e_am) | (i_req & ~e_ai));
      chk("err", err, e_err);

      ack_m_prev = e_am;
      ack_i_prev = e_ai;
      if (busy && c == g + 2 + w) begin
        busy      = 0;
        free_from = c + 1;
      end

      // Asynchronous reset in the middle of an access
      if (e_mreq && !mem_ready && resets < 3 &&
          ((resets == 0 && c > NCYC / 3) || $urandom_range(0, 15) == 0)) begin
        resets++;
        clrn = 1'b0;
        model_reset();
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk);
        @(negedge clk) clrn = 1'b1;
      end
    end

    chk("reset_seen", resets > 0, 1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_dmem_arb.md
Name: pipe_dmem_arb

Overview:
- Arbitrates the single-port memory between the MEM stage (load/store after the EX/MEM pipeline register) and the IF stage (instruction fetch).
- Sequences each access through a request/ready handshake and returns read data and a one-cycle acknowledge to the winning requester.
- Produces a pipeline stall that freezes the PC and all pipeline registers, EX/MEM included, until every pending request has been acknowledged.

Parameters:
- MAX_STARVE, 4: consecutive lost arbitrations after which IF wins over MEM; range 1..15.
- TIMEOUT_CYCLES, 64: ACCESS-state cycle limit; used only with PIPE_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- m_req  in  1  MEM-stage request (mwmem | mm2reg).
- m_we  in  1  MEM-stage write enable (mwmem).
- m_addr  in  32  MEM-stage byte address (malu).
- m_wdata  in  32  MEM-stage store data (mb).
- m_rdata  out  32  MEM-stage load data, registered.
- m_ack  out  1  MEM-stage completion pulse.
- i_req  in  1  IF-stage fetch request.
- i_addr  in  32  fetch address (pc).
- i_rdata  out  32  fetched instruction, registered.
- i_ack  out  1  IF-stage completion pulse.
- mem_req  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid when mem_ready=1.
- mem_ready  in  1  memory completion, sampled on clk.
- stall  out  1  freeze the pipeline.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (clrn=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: mem_req/we/addr/wdata, m_/i_rdata, m_/i_ack, err.
  - Starvation counter and winner register are cleared.
  - Reset asserted mid-ACCESS drops mem_req immediately. The aborted access is never acked.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If neither request is high, remain in IDLE.
  - Otherwise pick a winner:
    - Only one requester active: that requester wins.
    - Both active: MEM wins, unless the starvation count equals MAX_STARVE, in which case IF wins.
  - Latch winner, we, addr and wdata into registers on the clock edge, then go to ACCESS.
  - If IF wins, its we is 0 and its wdata is don't-care.
- ACCESS:
  - mem_req=1, with mem_we/addr/wdata held from the latched registers and stable throughout.
  - On a clk edge with mem_ready=1, capture mem_rdata into the winner's rdata register, go to RESP, and set the winner's ack for the next cycle.
  - On a write, the winner's rdata is left unchanged.
- RESP:
  - The winner's ack is 1 for exactly this cycle and mem_req=0.
  - No arbitration happens in RESP; this keeps a request that is still high during its own ack from being re-granted.
  - Next state is always IDLE.
- Latency: minimum 3 cycles from request to ack with zero-wait memory (IDLE grant, ACCESS, RESP). Each memory wait cycle adds 1.
- Starvation counter:
  - Increments by 1, saturating at MAX_STARVE, on each IDLE grant to MEM while i_req=1.
  - Clears on a grant to IF.
  - Is unchanged otherwise.
- Stall: stall = (m_req & ~m_ack) | (i_req & ~i_ack), combinational from registered acks.
- Requester contract:
  - Hold req/we/addr/wdata stable until ack.
  - The pipeline advances in the ack cycle; a new request may be presented the following cycle.
- The rdata registers hold their value until the next completed read for that requester.

Optional Feature:
- Macro: PIPE_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs while in ACCESS.
  - If mem_ready is still 0 after TIMEOUT_CYCLES ACCESS cycles, force RESP.
  - The winner's rdata becomes 32'hDEADBEEF, its ack pulses, and err sets sticky (cleared only by reset).
  - The counter clears on entry to ACCESS.
- Undefined: ACCESS waits indefinitely for mem_ready, no counter is built, and err is tied to 0.

Test Plan:
- MEM read only:
  - Stimulus: m_req=1, m_we=0, m_addr=0x10; memory ready in the first ACCESS cycle with rdata 0x1234_5678.
  - Required: mem_req high 1 cycle; m_ack in cycle 3; m_rdata=0x12345678; stall high cycles 1–2, low in cycle 3.
- MEM write with 2 wait states:
  - Stimulus: m_we=1, addr 0x20, wdata 0xCAFEF00D.
  - Required: mem_we/addr/wdata stable for 3 ACCESS cycles; m_ack in cycle 5; m_rdata unchanged.
- Simultaneous requests:
  - Stimulus: m_req=i_req=1, addr 0x40 and 0x0.
  - Required: MEM granted first; i_ack follows m_ack by ≥3 cycles; stall stays high until i_ack.
- Starvation:
  - Stimulus: MAX_STARVE=2; i_req held high while m_req is re-asserted each cycle after its ack.
  - Required: MEM granted twice, then IF granted; counter returns to 0.
- Reset mid-access:
  - Stimulus: clrn low during ACCESS with mem_ready=0.
  - Required: mem_req, acks and stall-related outputs go to 0 immediately; after release the state is IDLE and there is no spurious ack.
- Timeout (PIPE_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8):
  - Stimulus: mem_ready held at 0.
  - Required: ack after 8 ACCESS cycles; rdata=0xDEADBEEF; err=1 and remains set.
